// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-flow state encoding, default datapath
// widths, reset vector and NZP mask bit positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int          PC_W_DEF     = 16;
  localparam int          OFF_W_DEF    = 9;
  localparam logic [15:0] RESET_PC_DEF = 16'h3000;

  localparam int N_BIT = 2;
  localparam int Z_BIT = 1;
  localparam int P_BIT = 0;

endpackage

// File: rtl/nzp_match.sv
// Condition-code match: asserts when any flag selected by the mask is set.
//   mask  : [2]=n, [1]=z, [0]=p select bits
//   n,z,p : current flag values
//   match : |(mask & {n,z,p})
module nzp_match
  import cpu_pkg::*;
(
  input  logic [2:0] mask,
  input  logic       n,
  input  logic       z,
  input  logic       p,
  output logic       match
);

  logic [2:0] flags;

  always_comb begin
    flags        = '0;
    flags[N_BIT] = n;
    flags[Z_BIT] = z;
    flags[P_BIT] = p;
    match        = |(mask & flags);
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter / fetch sequencer with BR and JMP resolution.
//   clk, reset      : clock, synchronous active-high reset
//   en              : advance enable (0 = stall)
//   N, Z, P         : registered condition flags
//   fetch_ack       : instruction memory accepted the fetch at pc
//   br_valid/nzp/off: conditional branch, PC-relative 9-bit offset
//   jmp_valid/base  : register jump
//   halt_req        : stop sequencing until reset
//   pc, pc_valid    : fetch address and request (FETCH only)
//   taken           : one-cycle pulse in first FETCH of a redirected PC
//   halted          : high in HALT
module branch_pc_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              OFF_W    = OFF_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             N,
  input  logic             Z,
  input  logic             P,
  input  logic             fetch_ack,
  input  logic             br_valid,
  input  logic [2:0]       br_nzp,
  input  logic [OFF_W-1:0] br_off,
  input  logic             jmp_valid,
  input  logic [PC_W-1:0]  jmp_base,
  input  logic             halt_req,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic             taken,
  output logic             halted
);

  state_t          state, state_n;
  logic [PC_W-1:0] pc_n;
  logic            taken_n;
  logic            br_match;
  logic [PC_W-1:0] br_sext;

  nzp_match u_nzp_match (
    .mask  (br_nzp),
    .n     (N),
    .z     (Z),
    .p     (P),
    .match (br_match)
  );

  assign br_sext = {{(PC_W-OFF_W){br_off[OFF_W-1]}}, br_off};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      taken <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      taken <= taken_n;
    end
  end

  // taken defaults low so it is a single-cycle pulse and clears under stall.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    taken_n = 1'b0;
    if (en) begin
      case (state)
        IDLE: state_n = FETCH;
        FETCH: begin
          if (fetch_ack) begin
            pc_n    = pc + PC_W'(1);
            state_n = EXEC;
          end
        end
        EXEC: begin
          state_n = FETCH;
          if (halt_req) begin
            state_n = HALT;
          end else if (jmp_valid) begin
            pc_n    = jmp_base;
            taken_n = 1'b1;
          end else if (br_valid && br_match) begin
            pc_n    = pc + br_sext;
            taken_n = 1'b1;
          end
        end
        HALT:    state_n = HALT;
        default: state_n = IDLE;
      endcase
    end
  end

  // Gated by reset so no fetch or halt is advertised while reset is held.
  assign pc_valid = (state == FETCH) && !reset;
  assign halted   = (state == HALT)  && !reset;

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Sits directly downstream of the NZP flag register.
- Owns the program counter and issues instruction fetches over a valid/ack handshake.
- Resolves conditional branches (BR nzp, PCoffset9) against the registered N/Z/P flags, plus unconditional register jumps (JMP).
- Next fetch address feeds instruction memory; the branch-taken pulse feeds control.

Parameters:
- PC_W, 16, program counter and jump base width.
- OFF_W, 9, branch offset width (two's complement, sign-extended to PC_W).
- RESET_PC, 16'h3000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- en  input  1  advance enable; 0 freezes state and PC (stall).
- N  input  1  negative flag from the flag register.
- Z  input  1  zero flag from the flag register.
- P  input  1  positive flag from the flag register.
- fetch_ack  input  1  instruction memory accepted the current fetch.
- br_valid  input  1  decoded BR instruction present (sampled in EXEC only).
- br_nzp  input  3  condition mask: [2]=n, [1]=z, [0]=p.
- br_off  input  OFF_W  PCoffset9, two's complement.
- jmp_valid  input  1  decoded JMP present (sampled in EXEC only).
- jmp_base  input  PC_W  base register value for JMP.
- halt_req  input  1  decoded HALT (sampled in EXEC only).
- pc  output  PC_W  current PC / fetch address.
- pc_valid  output  1  fetch request; high only in FETCH.
- taken  output  1  registered one-cycle pulse: redirect occurred.
- halted  output  1  high while in HALT.

Behaviour:
- States: IDLE, FETCH, EXEC, HALT.
- Reset (sync): state<=IDLE, pc<=RESET_PC, taken<=0. pc_valid=0 and halted=0 during reset and in IDLE. Reset overrides everything, including en=0, mid-fetch, mid-EXEC and HALT.
- IDLE: if en, go to FETCH next cycle.
- FETCH: pc_valid=1, pc stable.
  - On fetch_ack && en: pc<=pc+1 (mod 2^PC_W; 16'hFFFF wraps to 16'h0000), go to EXEC.
  - With no ack, hold pc and pc_valid.
- EXEC (one cycle when en=1; held while en=0). Priority: halt_req > jmp_valid > br_valid.
  - halt_req: pc unchanged, go to HALT.
  - jmp_valid: pc<=jmp_base, taken<=1, go to FETCH.
  - br_valid with (br_nzp & {N,Z,P})!=0: pc<=pc+sext(br_off) mod 2^PC_W, taken<=1, go to FETCH. Here pc is the already-incremented value.
  - br_valid with no match, or no request: pc unchanged, taken<=0, go to FETCH.
  - br_nzp=000 is never taken; 111 is always taken.
- Flags are sampled combinationally in the EXEC cycle. A flag update written on that same edge is not visible until the next EXEC.
- taken: high exactly one cycle, the first FETCH cycle of the redirected PC; otherwise 0.
- HALT: halted=1, pc_valid=0, pc frozen. Exit only via reset.
- en=0 in any state: no state, pc or taken change, except that taken clears to 0. pc_valid still reflects the state.
- Inputs outside EXEC are ignored. fetch_ack outside FETCH is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum {IDLE, FETCH, EXEC, HALT};
  - PC_W and OFF_W defaults, RESET_PC;
  - NZP bit index constants N_BIT=2, Z_BIT=1, P_BIT=0.
- One sub-module: nzp_match, combinational. Inputs nzp mask and N/Z/P; output match = |(mask & {N,Z,P}). Reused by any future conditional-select logic.

Test Plan:
- Reset, then en=1, ack on first FETCH: pc=16'h3000, pc_valid high in cycle 2 after reset release. After ack, pc=16'h3001 in EXEC.
- pc=16'h3001 in EXEC, flags N=0 Z=1 P=0, br_nzp=010, br_off=9'h1FE (-2) -> pc=16'h2FFF, taken=1 for one cycle. Same stimulus with br_nzp=101 -> pc stays 16'h3001, taken=0.
- Wrap-around:
  - FETCH at pc=16'hFFFF with ack -> pc=16'h0000.
  - br_off=9'h0FF from pc=16'hFF80 -> pc=16'h007F.
- Priority: jmp_valid=1, jmp_base=16'h4000 together with taken-eligible br_valid -> pc=16'h4000. halt_req in the same EXEC -> HALT, pc unchanged, halted=1, later ack/br ignored.
- Stall: fetch_ack withheld 3 cycles, then en=0 for 2 cycles in EXEC with br_valid held -> pc and state frozen. Branch resolves on the first en=1 cycle.
- Reset mid-operation: reset asserted in EXEC with a taken branch pending -> next cycle pc=16'h3000, IDLE, taken=0. Reset in HALT -> halted=0.
